// File: rtl/fir_decim_fifo_if.sv
// Stream bundle between the FIR output stage and its environment.
// Latency: none (wires only); the slave side is the decimating FIFO.
// Backpressure: m_ready_i stalls the output stream only; the filter side never stalls.
interface fir_decim_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                            clear_i;
    logic                            in_valid_i;
    logic signed [DATA_WIDTH-1:0]    data_i;
    logic signed [DATA_WIDTH-1:0]    m_data_o;
    logic                            m_valid_o;
    logic                            m_ready_i;
    logic [$clog2(FIFO_DEPTH):0]     level_o;
    logic                            full_o;
    logic                            ovf_o;

    // Decimator / FIFO side
    modport slave (
        input  clear_i, in_valid_i, data_i, m_ready_i,
        output m_data_o, m_valid_o, level_o, full_o, ovf_o
    );

    // Filter + consumer side
    modport master (
        output clear_i, in_valid_i, data_i, m_ready_i,
        input  m_data_o, m_valid_o, level_o, full_o, ovf_o
    );
endinterface

// File: rtl/fir_decim_fifo.sv
// Keeps 1 of every DECIM filter samples (or their floor average with FIR_DECIM_FIFO_ACCUM_EN) into a FWFT FIFO.
// Latency: a sample pushed at edge N is visible on m_data_o/m_valid_o right after edge N.
// Backpressure: m_ready_i only drains the FIFO; when full without a pop the kept sample is dropped and ovf_o sticks.
module fir_decim_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fir_decim_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [PW-1:0]                r_phase;
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                r_rd_ptr;
    logic [AW:0]                  r_level;
    logic                         r_ovf;
    logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic                         w_full;
    logic                         w_valid;
    logic                         w_pop;
    logic                         w_push_req;
    logic                         w_push;
    logic                         w_drop;
    logic signed [DATA_WIDTH-1:0] w_push_dat;

`ifdef FIR_DECIM_FIFO_ACCUM_EN
    localparam int SH    = $clog2(DECIM);
    localparam int ACC_W = DATA_WIDTH + SH;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_data_ext;
    logic signed [ACC_W-1:0] w_sum;

    // Phase 0 restarts the running sum; the last phase emits the floored mean.
    assign w_data_ext = ACC_W'(bus.data_i);
    assign w_sum      = (r_phase == '0) ? w_data_ext : (r_acc + w_data_ext);
    assign w_push_dat = DATA_WIDTH'(w_sum >>> SH);
    assign w_push_req = bus.in_valid_i && (r_phase == PH_LAST);

    // Running sum of the samples of the current decimation window
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else if (bus.clear_i) begin
            r_acc <= '0;
        end else if (bus.in_valid_i) begin
            r_acc <= w_sum;
        end
    end
`else
    assign w_push_dat = bus.data_i;
    assign w_push_req = bus.in_valid_i && (r_phase == '0);
`endif

    assign w_full  = (r_level == LVL_FULL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && bus.m_ready_i;
    // A simultaneous pop frees the slot the push needs.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    assign bus.m_data_o  = r_mem[r_rd_ptr];
    assign bus.m_valid_o = w_valid;
    assign bus.level_o   = r_level;
    assign bus.full_o    = w_full;
    assign bus.ovf_o     = r_ovf;

    // Decimation phase: counts valid samples modulo DECIM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase <= '0;
        end else if (bus.clear_i) begin
            r_phase <= '0;
        end else if (bus.in_valid_i) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : (r_phase + PH_ONE);
        end
    end

    // FIFO storage; reset clears it so m_data_o reads 0 out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (!bus.clear_i && w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo: a sample-level reference model queues expected outputs,
// a negedge monitor compares the head, valid, level, full and overflow flags.
// Stimulus: directed scenarios followed by randomized traffic with random stalls and clears.
`timescale 1ns/1ps
module tb_fir_decim_fifo;
    localparam int DW    = 8;
    localparam int DECIM = 4;
    localparam int DEPTH = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    fir_decim_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    fir_decim_fifo #(
        .DATA_WIDTH(DW),
        .DECIM     (DECIM),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int exp_q[$];
    int m_lvl = 0;
    int m_ovf = 0;
    int m_n   = 0;
    int m_sum = 0;

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        int  d;
        int  val;
        bit  push_req;
        bit  pop;
        bit  full;
        if (rst_i || bus.clear_i) begin
            exp_q.delete();
            m_lvl = 0;
            m_ovf = 0;
            m_n   = 0;
            m_sum = 0;
        end else begin
            push_req = 1'b0;
            val      = 0;
            pop      = (m_lvl > 0) && bus.m_ready_i;
            full     = (m_lvl == DEPTH);
            if (bus.in_valid_i) begin
                d = $signed(bus.data_i);
`ifdef FIR_DECIM_FIFO_ACCUM_EN
                if (m_n % DECIM == 0) m_sum = d;
                else m_sum = m_sum + d;
                if (m_n % DECIM == DECIM - 1) begin
                    push_req = 1'b1;
                    val      = floor_div(m_sum, DECIM);
                end
`else
                if (m_n % DECIM == 0) begin
                    push_req = 1'b1;
                    val      = d;
                end
`endif
                m_n++;
            end
            if (pop) m_lvl--;
            if (push_req) begin
                if (!full || pop) begin
                    exp_q.push_back(val);
                    m_lvl++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        chk("m_valid", int'(bus.m_valid_o), int'(m_lvl > 0));
        chk("level", int'(bus.level_o), m_lvl);
        chk("full", int'(bus.full_o), int'(m_lvl == DEPTH));
        chk("ovf", int'(bus.ovf_o), m_ovf);
        if (m_lvl > 0 && exp_q.size() > 0) begin
            chk("m_data", int'($signed(bus.m_data_o)), exp_q[0]);
            if (bus.m_ready_i) void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int d, input bit rdy, input bit clr);
        bus.in_valid_i = v;
        bus.data_i     = DW'(d);
        bus.m_ready_i  = rdy;
        bus.clear_i    = clr;
        @(posedge clk_i);
        #1;
    endtask

    int vec6[16] = '{10, 20, 30, 40, -128, -128, -128, -128,
                     127, 127, 127, 126, -1, 0, 0, 0};

    initial begin
        bus.in_valid_i = 1'b0;
        bus.data_i     = '0;
        bus.m_ready_i  = 1'b0;
        bus.clear_i    = 1'b0;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_data", int'($signed(bus.m_data_o)), 0);
        chk("rst_valid", int'(bus.m_valid_o), 0);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // ramp with free-running consumer
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 1'b1, 1'b0);

        // stalled consumer: fill, overflow, then drain
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("t2_level", int'(bus.level_o), DEPTH);
        chk("t2_full", int'(bus.full_o), 1);
        chk("t2_ovf", int'(bus.ovf_o), 1);
        repeat (12) step(1'b0, 0, 1'b1, 1'b0);
        chk("t2_drained", int'(bus.level_o), 0);
        chk("t2_ovf_sticky", int'(bus.ovf_o), 1);

        // full FIFO with simultaneous pop and push
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, i + 50, 1'b0, 1'b0);
        chk("t3_full_level", int'(bus.level_o), DEPTH);
        step(1'b1, 100, 1'b1, 1'b0);
        chk("t3_ovf", int'(bus.ovf_o), 0);
        repeat (12) step(1'b0, 0, 1'b1, 1'b0);

        // clear mid-window; sample on the clear cycle is ignored
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b1, 55, 1'b0, 1'b1);
        chk("t4_level", int'(bus.level_o), 0);
        chk("t4_ovf", int'(bus.ovf_o), 0);
        step(1'b1, -7, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, i, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 1'b1, 1'b0);

        // asynchronous reset with a partly filled FIFO
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("t5_pre_level", int'(bus.level_o), 5);
        bus.in_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("t5_rst_level", int'(bus.level_o), 0);
        chk("t5_rst_valid", int'(bus.m_valid_o), 0);
        chk("t5_rst_data", int'($signed(bus.m_data_o)), 0);
        chk("t5_rst_full", int'(bus.full_o), 0);
        chk("t5_rst_ovf", int'(bus.ovf_o), 0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 1'b1, 1'b0);

        // averaging corner vectors (plain picks when averaging is off)
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, vec6[i], 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, int'($urandom_range(0, 255)) - 128,
                 ($urandom % 10) < 6, ($urandom % 200) == 0);
        end
        repeat (20) step(1'b0, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
